// File: rtl/ram_copy_master_if.sv
// Port bundle for ram_copy_master: copy request/status plus the RAM-side strobes,
// address and data buses.
interface ram_copy_master_if;
  logic        start;
  logic [15:0] srcAddr;
  logic [15:0] dstAddr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        chipsel;
  logic        readEn;
  logic        writeEn;
  logic [15:0] addrOut;
  logic [7:0]  dataOut;
  logic [7:0]  dataIn;

  modport master (
    input  start, srcAddr, dstAddr, len, dataIn,
    output busy, done, chipsel, readEn, writeEn, addrOut, dataOut
  );

  modport slave (
    output start, srcAddr, dstAddr, len, dataIn,
    input  busy, done, chipsel, readEn, writeEn, addrOut, dataOut
  );
endinterface

// File: rtl/ram_copy_master.sv
// Byte-wise RAM-to-RAM copy engine: read one byte, wait RD_LAT cycles, write it,
// repeat for len bytes in ascending order, then pulse done for one cycle.
module ram_copy_master #(
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_copy_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t      state_r, state_s;
  logic [15:0] src_r, src_s;
  logic [15:0] dst_r, dst_s;
  logic [15:0] len_r, len_s;
  logic [15:0] idx_r, idx_s;
  logic [1:0]  wait_r, wait_s;
  logic [7:0]  data_r, data_s;
  logic [15:0] addr_r, addr_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        cs_r, cs_s;
  logic        rd_r, rd_s;
  logic        wr_r, wr_s;

  // Next-state, captured request and byte index/latency counters.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    len_s   = len_r;
    idx_s   = idx_r;
    wait_s  = wait_r;
    data_s  = data_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          src_s   = bus.srcAddr;
          dst_s   = bus.dstAddr;
          len_s   = bus.len;
          idx_s   = 16'd0;
          state_s = (bus.len != 16'd0) ? RD_ISSUE : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ISSUE: begin
        wait_s  = 2'd0;
        state_s = RD_WAIT;
      end
      RD_WAIT: begin
        // The write data register doubles as dataOut, so it only changes here.
        if (wait_r == WAIT_LAST) begin
          data_s  = bus.dataIn;
          state_s = WR;
        end else begin
          wait_s  = wait_r + 2'd1;
        end
      end
      WR: begin
        idx_s   = idx_r + 16'd1;
        state_s = ((idx_r + 16'd1) != len_r) ? RD_ISSUE : DONE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    cs_s   = 1'b0;
    rd_s   = 1'b0;
    wr_s   = 1'b0;
    addr_s = addr_r;
    case (state_s)
      RD_ISSUE: begin
        busy_s = 1'b1;
        cs_s   = 1'b1;
        rd_s   = 1'b1;
        addr_s = src_s + idx_s;
      end
      RD_WAIT: begin
        busy_s = 1'b1;
        cs_s   = 1'b1;
      end
      WR: begin
        busy_s = 1'b1;
        cs_s   = 1'b1;
        wr_s   = 1'b1;
        addr_s = dst_s + idx_s;
      end
      DONE:    done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // State, context and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      src_r   <= 16'h0000;
      dst_r   <= 16'h0000;
      len_r   <= 16'h0000;
      idx_r   <= 16'h0000;
      wait_r  <= 2'd0;
      data_r  <= 8'h00;
      addr_r  <= 16'h0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cs_r    <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      len_r   <= len_s;
      idx_r   <= idx_s;
      wait_r  <= wait_s;
      data_r  <= data_s;
      addr_r  <= addr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cs_r    <= cs_s;
      rd_r    <= rd_s;
      wr_r    <= wr_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.chipsel = cs_r;
  assign bus.readEn  = rd_r;
  assign bus.writeEn = wr_r;
  assign bus.addrOut = addr_r;
  assign bus.dataOut = data_r;

endmodule
